// File: rtl/sequential_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : sequential_multiplier
// Description : Iterative shift-and-add unsigned multiplier, one multiplier
//               bit per clock, start/busy/done handshake.
//               Optional SEQ_MULT_EARLY_EXIT_EN: finish as soon as the
//               remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sequential_multiplier #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 8
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic                       start,
    input  logic [WIDTH_A-1:0]         multiplicand,
    input  logic [WIDTH_B-1:0]         multiplier,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
    output logic                       busy,
    output logic                       done
);

    localparam int c_PW = WIDTH_A + WIDTH_B;
    localparam int c_CW = $clog2(WIDTH_B) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH_B - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_PW-1:0]     r_acc;
    logic [c_PW-1:0]     r_mcand;
    logic [c_PW-1:0]     r_product;
    logic [WIDTH_B-1:0]  r_mplier;
    logic [c_CW-1:0]     r_count;

    logic                w_accept;
    logic                w_last;
    logic [c_PW-1:0]     w_sum;
    logic [WIDTH_B-1:0]  w_mplier_sh;

    // New operands are accepted from IDLE and from DONE (back-to-back).
    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_sum       = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_sh = r_mplier >> 1;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign w_last = (r_count == c_LAST) || (w_mplier_sh == '0);
`else
    assign w_last = (r_count == c_LAST);
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_MULT;
                end
            end
            S_MULT: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = start ? S_MULT : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc     <= '0;
            r_mcand   <= {{WIDTH_B{1'b0}}, multiplicand};
            r_mplier  <= multiplier;
            r_count   <= '0;
        end else if (r_state == S_MULT) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_sh;
            r_count  <= r_count + 1'b1;
            // The final edge's add goes straight into the result register.
            if (w_last) begin
                r_product <= w_sum;
            end
        end
    end

    assign product = r_product;
    assign busy    = (r_state == S_MULT);
    assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sequential_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequential_multiplier
// Description : Self-checking bench for sequential_multiplier, directed and
//               random operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_multiplier;

    localparam int WIDTH_A = 16;
    localparam int WIDTH_B = 8;

    logic                       clk;
    logic                       nRst;
    logic                       start;
    logic [WIDTH_A-1:0]         multiplicand;
    logic [WIDTH_B-1:0]         multiplier;
    logic [WIDTH_A+WIDTH_B-1:0] product;
    logic                       busy;
    logic                       done;

    int total;
    int bad;

    sequential_multiplier #(
        .WIDTH_A(WIDTH_A),
        .WIDTH_B(WIDTH_B)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .product     (product),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [WIDTH_A-1:0] a, input logic [WIDTH_B-1:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = 64'(a);
        wb = 64'(b);
        return wa * wb;
    endfunction

    // Cycles from the accepting edge to the done cycle.
    function automatic int ref_lat(input logic [WIDTH_B-1:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int msb;
        msb = 1;
        for (int i = 0; i < WIDTH_B; i++) begin
            if (b[i]) msb = i + 1;
        end
        return msb;
`else
        return (b == b) ? WIDTH_B : WIDTH_B;
`endif
    endfunction

    // Launch an operation; returns #1 after the accepting edge.
    task automatic start_op(input logic [WIDTH_A-1:0] a, input logic [WIDTH_B-1:0] b);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; 'already' edges since acceptance have elapsed.
    task automatic wait_done(input string tag, input logic [63:0] exp_p, input int exp_lat, input int already);
        int n;
        bit seen;
        bit busy_ok;
        n       = already;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < 4 * WIDTH_B) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_product"}, 64'(product), exp_p);
    endtask

    initial begin
        logic [WIDTH_A-1:0] ra;
        logic [WIDTH_B-1:0] rb;
        total        = 0;
        bad          = 0;
        nRst         = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        @(negedge clk);
        nRst = 1'b1;

        // Basic multiply and result hold
        start_op(16'd12, 8'd10);
        chk("basic_busy_e0", 64'(busy), 64'd1);
        wait_done("basic", ref_prod(16'd12, 8'd10), ref_lat(8'd10), 0);
        @(posedge clk);
        #1;
        chk("basic_done_pulse", 64'(done), 64'd0);
        repeat (9) @(posedge clk);
        #1;
        chk("basic_hold", 64'(product), 64'd120);
        chk("basic_idle_busy", 64'(busy), 64'd0);

        // Maximum operands and zero multiplicand
        start_op(16'hFFFF, 8'hFF);
        wait_done("max", 64'h00FE_FF01, ref_lat(8'hFF), 0);
        start_op(16'h0000, 8'hAA);
        wait_done("zero_a", ref_prod(16'h0000, 8'hAA), ref_lat(8'hAA), 0);

        // start and operand changes during MULT are ignored
        start_op(16'd3, 8'd5);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'd7;
        multiplier   = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_ign", 64'd15, ref_lat(8'd5), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_ign_idle_busy", 64'(busy), 64'd0);
        chk("busy_ign_idle_done", 64'(done), 64'd0);
        chk("busy_ign_hold", 64'(product), 64'd15);

        // Back-to-back: start held through the DONE cycle
        start_op(16'd100, 8'd2);
        repeat (ref_lat(8'd2) - 1) @(posedge clk);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'd9;
        multiplier   = 8'd9;
        @(posedge clk);
        #1;
        chk("b2b_first_done", 64'(done), 64'd1);
        chk("b2b_first_product", 64'(product), 64'd200);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_second_busy", 64'(busy), 64'd1);
        wait_done("b2b_second", 64'd81, ref_lat(8'd9), 0);

        // Asynchronous reset in the middle of an operation
        start_op(16'd50, 8'd50);
        repeat (3) @(posedge clk);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        chk("midrst_product", 64'(product), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        nRst = 1'b1;
        begin
            bit any_done;
            any_done = 1'b0;
            repeat (2 * WIDTH_B) begin
                @(posedge clk);
                #1;
                if (done || busy) any_done = 1'b1;
            end
            chk("midrst_quiet", 64'(any_done), 64'd0);
        end
        start_op(16'd6, 8'd7);
        wait_done("after_rst", 64'd42, ref_lat(8'd7), 0);

        // Early-exit boundary cases (full length when the feature is off)
        start_op(16'd300, 8'd1);
        wait_done("mplier_one", 64'd300, ref_lat(8'd1), 0);
        start_op(16'd300, 8'h80);
        wait_done("mplier_msb", ref_prod(16'd300, 8'h80), ref_lat(8'h80), 0);
        start_op(16'd1234, 8'd0);
        wait_done("mplier_zero", 64'd0, ref_lat(8'd0), 0);

        // Random operations
        for (int k = 0; k < 20; k++) begin
            ra = WIDTH_A'($urandom);
            rb = WIDTH_B'($urandom);
            start_op(ra, rb);
            wait_done("rand", ref_prod(ra, rb), ref_lat(rb), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
